pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the Ludi-V core; successor to the fixed 64-bit branch-on-zero PC. Holds the fetch address and computes next-PC for sequential flow, all six RV conditional branches, JAL, JALR, trap entry and MRET. Adds a fetch handshake, stall, misaligned-target fault state and a retired-instruction counter. Sits between the decode/ALU stage and instruction memory.

## Interface

- p_XLEN, 64, address/data width (32 or 64)
- p_RESET_VECTOR, 0, o_PC value while in reset
- p_IALIGN, 4, instruction alignment in bytes (4, or 2 for compressed support)
- i_Clock  in  1  core clock, all state updates on rising edge
- i_Reset  in  1  reset, synchronous and active-high
- i_Stall  in  1  hold PC and counter this cycle
- i_FetchReady  in  1  instruction memory accepts o_PC
- i_Branch  in  1  current instruction is a conditional branch
- i_BranchOp  in  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- i_Eq, i_Lt, i_Ltu  in  1 each  ALU compare flags for rs1 vs rs2
- i_Jal, i_Jalr  in  1 each  jump type
- i_Immediate  in  p_XLEN  sign-extended offset
- i_Rs1  in  p_XLEN  JALR base
- i_Trap  in  1  take trap
- i_TrapVector  in  p_XLEN  trap handler base
- i_Mret  in  1  return from trap
- i_Epc  in  p_XLEN  return address for MRET
- o_PC  out  p_XLEN  current fetch address
- o_PCLink  out  p_XLEN  o_PC + p_IALIGN (rd value for JAL/JALR)
- o_FetchValid  out  1  o_PC is a valid fetch request
- o_Taken  out  1  control transfer selected this cycle (comb)
- o_Misaligned  out  1  one-cycle fault pulse
- o_BadAddr  out  p_XLEN  faulting target, held until next fault or reset
- o_InstRet  out  64  count of accepted (retired) fetches

## Operation

- FSM states: BOOT, RUN, FAULT.
- BOOT: o_FetchValid=0; next cycle -> RUN unconditionally.
- RUN: o_FetchValid=1. Advance = i_FetchReady && !i_Stall.
- Next-PC priority (highest first): i_Reset; i_Trap -> {i_TrapVector[p_XLEN-1:2],2'b00}; i_Mret -> i_Epc; no advance -> hold; i_Jalr -> (i_Rs1+i_Immediate) with bit0 cleared; i_Jal -> o_PC+i_Immediate; i_Branch with condition true -> o_PC+i_Immediate; else o_PC+p_IALIGN.
- i_Trap and i_Mret apply regardless of i_Stall/i_FetchReady and from any state; both move FSM to RUN. Trap wins over MRET.
- Branch condition: BEQ i_Eq, BNE !i_Eq, BLT i_Lt, BGE !i_Lt, BLTU i_Ltu, BGEU !i_Ltu; funct3 010/011 -> not taken.
- o_Taken=1 when advance and (JAL, JALR, or taken branch).
- Misaligned: if a taken target mod p_IALIGN != 0, PC holds, o_Misaligned=1 next cycle, o_BadAddr=target, FSM -> FAULT, o_InstRet not incremented.
- FAULT: o_FetchValid=0, PC held; leaves only on i_Trap, i_Mret or reset.
- o_InstRet increments by 1 on each advance in RUN (incl. taken transfers); wraps at 2^64.
- All adds modulo 2^p_XLEN; no overflow flag.

## Timing

- Reset values: o_PC=p_RESET_VECTOR, FSM=BOOT, o_FetchValid=0, o_Misaligned=0, o_BadAddr=0, o_InstRet=0.
- First cycle after reset deasserts: BOOT; second: RUN, fetch of p_RESET_VECTOR.
- o_PC, o_InstRet, o_Misaligned, o_BadAddr registered; next-PC, o_PCLink, o_Taken combinational.
- Redirect latency one cycle: target visible on o_PC after the edge that samples the control inputs.
- Reset asserted mid-operation (any state, including FAULT) wins at the next edge.
- Control inputs ignored in BOOT and FAULT except i_Trap/i_Mret.

## Structure

- Shared package pc_pkg: branch funct3 constants, FSM state encoding.
- One sub-module: branch_cond (i_BranchOp + flags -> taken), combinational, reusable by the ALU stage.
- Remainder flat in pc_unit.

## Test plan

- Reset then 4 cycles, i_FetchReady=1, no control: o_PC 0 (BOOT), 0, 4, 8; o_InstRet=2.
- o_PC=0x100, BNE with i_Eq=0, imm=-8 -> o_PC=0xF8, o_Taken=1; same with i_Eq=1 -> 0x104.
- JALR i_Rs1=0x201, imm=3 -> o_PC=0x204; o_PCLink before edge = o_PC+4.
- JAL imm=6, p_IALIGN=4 -> PC held, o_Misaligned pulse, o_BadAddr=PC+6, FAULT; i_Trap with vector 0x803 -> o_PC=0x800, RUN.
- i_Stall=1 plus i_Jal -> PC and counter held; i_Trap concurrent with i_Mret and i_Stall -> trap vector taken.
- p_XLEN=32, o_PC=0xFFFFFFFC, sequential -> 0x00000000 wrap; reset mid-FAULT -> p_RESET_VECTOR, BOOT.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit and any stage that evaluates
// RV conditional branches (funct3 codes, PC-unit FSM encoding).
package pc_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } pc_state_t;

endpackage

// File: rtl/branch_cond.sv
// Resolves an RV conditional branch from its funct3 and the ALU compare flags.
// Purely combinational so the ALU stage can reuse it unchanged.
module branch_cond
    import pc_pkg::*;
(
    input  logic [2:0] i_BranchOp,
    input  logic       i_Eq,
    input  logic       i_Lt,
    input  logic       i_Ltu,
    output logic       o_Cond
);

    always_comb begin
        o_Cond = 1'b0;
        case (i_BranchOp)
            F3_BEQ:  o_Cond = i_Eq;
            F3_BNE:  o_Cond = !i_Eq;
            F3_BLT:  o_Cond = i_Lt;
            F3_BGE:  o_Cond = !i_Lt;
            F3_BLTU: o_Cond = i_Ltu;
            F3_BGEU: o_Cond = !i_Ltu;
            default: o_Cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch address register, next-PC selection for
// sequential flow, branches, JAL/JALR, trap entry and MRET, plus retire counter.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned         p_XLEN         = 64,
    parameter logic [p_XLEN-1:0]   p_RESET_VECTOR = '0,
    parameter int unsigned         p_IALIGN       = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Stall,
    input  logic              i_FetchReady,
    input  logic              i_Branch,
    input  logic [2:0]        i_BranchOp,
    input  logic              i_Eq,
    input  logic              i_Lt,
    input  logic              i_Ltu,
    input  logic              i_Jal,
    input  logic              i_Jalr,
    input  logic [p_XLEN-1:0] i_Immediate,
    input  logic [p_XLEN-1:0] i_Rs1,
    input  logic              i_Trap,
    input  logic [p_XLEN-1:0] i_TrapVector,
    input  logic              i_Mret,
    input  logic [p_XLEN-1:0] i_Epc,
    output logic [p_XLEN-1:0] o_PC,
    output logic [p_XLEN-1:0] o_PCLink,
    output logic              o_FetchValid,
    output logic              o_Taken,
    output logic              o_Misaligned,
    output logic [p_XLEN-1:0] o_BadAddr,
    output logic [63:0]       o_InstRet
);

    localparam logic [p_XLEN-1:0] c_IALIGN     = p_XLEN'(p_IALIGN);
    localparam logic [p_XLEN-1:0] c_ALIGN_MASK = p_XLEN'(p_IALIGN - 1);
    localparam logic [p_XLEN-1:0] c_TRAP_MASK  = ~p_XLEN'(3);
    localparam logic [p_XLEN-1:0] c_JALR_MASK  = ~p_XLEN'(1);

    pc_state_t         state;
    logic [p_XLEN-1:0] pc_q;
    logic [p_XLEN-1:0] bad_addr_q;
    logic [63:0]       inst_ret_q;
    logic              misaligned_q;

    logic              cond_taken;
    logic              advance;
    logic              transfer;
    logic              target_misaligned;
    logic [p_XLEN-1:0] seq_pc;
    logic [p_XLEN-1:0] jalr_sum;
    logic [p_XLEN-1:0] target;
    logic [p_XLEN-1:0] trap_pc;

    branch_cond u_branch_cond (
        .i_BranchOp (i_BranchOp),
        .i_Eq       (i_Eq),
        .i_Lt       (i_Lt),
        .i_Ltu      (i_Ltu),
        .o_Cond     (cond_taken)
    );

    assign advance  = (state == ST_RUN) && i_FetchReady && !i_Stall;
    assign transfer = i_Jal || i_Jalr || (i_Branch && cond_taken);
    assign seq_pc   = pc_q + c_IALIGN;
    assign jalr_sum = i_Rs1 + i_Immediate;
    assign trap_pc  = i_TrapVector & c_TRAP_MASK;

    // JALR outranks JAL, which outranks a taken branch
    always_comb begin
        if (i_Jalr) begin
            target = jalr_sum & c_JALR_MASK;
        end else if (transfer) begin
            target = pc_q + i_Immediate;
        end else begin
            target = seq_pc;
        end
    end

    assign target_misaligned = transfer && ((target & c_ALIGN_MASK) != '0);

    assign o_PC         = pc_q;
    assign o_PCLink     = seq_pc;
    assign o_FetchValid = (state == ST_RUN);
    assign o_Taken      = advance && transfer;
    assign o_Misaligned = misaligned_q;
    assign o_BadAddr    = bad_addr_q;
    assign o_InstRet    = inst_ret_q;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state        <= ST_BOOT;
            pc_q         <= p_RESET_VECTOR;
            misaligned_q <= 1'b0;
            bad_addr_q   <= '0;
            inst_ret_q   <= '0;
        end else begin
            misaligned_q <= 1'b0;
            // Trap and MRET are honoured in every state, even when stalled
            if (i_Trap) begin
                pc_q  <= trap_pc;
                state <= ST_RUN;
            end else if (i_Mret) begin
                pc_q  <= i_Epc;
                state <= ST_RUN;
            end else begin
                case (state)
                    ST_BOOT: state <= ST_RUN;
                    ST_RUN: begin
                        if (advance) begin
                            if (target_misaligned) begin
                                misaligned_q <= 1'b1;
                                bad_addr_q   <= target;
                                state        <= ST_FAULT;
                            end else begin
                                pc_q       <= target;
                                inst_ret_q <= inst_ret_q + 64'd1;
                            end
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed table of the main scenarios, a 32-bit wrap
// sequence, and randomized traffic checked against a behavioural model.
module tb_pc_unit;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        rdy;
        logic        br;
        logic [2:0]  op;
        logic        eq;
        logic        lt;
        logic        ltu;
        logic        jal;
        logic        jalr;
        logic [63:0] imm;
        logic [63:0] rs1;
        logic        trap;
        logic [63:0] tv;
        logic        mret;
        logic [63:0] epc;
    } ctrl_t;

    typedef struct {
        ctrl_t       c;
        logic        taken;
        logic [63:0] link;
        logic [63:0] pc;
        logic [63:0] ir;
        logic        fv;
        logic        mis;
        logic [63:0] bad;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    ctrl_t c64;
    ctrl_t c32;

    logic [63:0] pc64, link64, bad64, ir64;
    logic        fv64, taken64, mis64;
    logic [31:0] pc32, link32, bad32;
    logic [63:0] ir32;
    logic        fv32, taken32, mis32;

    int n_vec = 0;
    int n_bad = 0;

    pc_unit #(.p_XLEN(64), .p_RESET_VECTOR(64'h0), .p_IALIGN(4)) dut (
        .i_Clock(clk), .i_Reset(c64.rst), .i_Stall(c64.stall), .i_FetchReady(c64.rdy),
        .i_Branch(c64.br), .i_BranchOp(c64.op), .i_Eq(c64.eq), .i_Lt(c64.lt), .i_Ltu(c64.ltu),
        .i_Jal(c64.jal), .i_Jalr(c64.jalr), .i_Immediate(c64.imm), .i_Rs1(c64.rs1),
        .i_Trap(c64.trap), .i_TrapVector(c64.tv), .i_Mret(c64.mret), .i_Epc(c64.epc),
        .o_PC(pc64), .o_PCLink(link64), .o_FetchValid(fv64), .o_Taken(taken64),
        .o_Misaligned(mis64), .o_BadAddr(bad64), .o_InstRet(ir64)
    );

    pc_unit #(.p_XLEN(32), .p_RESET_VECTOR(32'h1000), .p_IALIGN(4)) dut32 (
        .i_Clock(clk), .i_Reset(c32.rst), .i_Stall(c32.stall), .i_FetchReady(c32.rdy),
        .i_Branch(c32.br), .i_BranchOp(c32.op), .i_Eq(c32.eq), .i_Lt(c32.lt), .i_Ltu(c32.ltu),
        .i_Jal(c32.jal), .i_Jalr(c32.jalr), .i_Immediate(c32.imm[31:0]), .i_Rs1(c32.rs1[31:0]),
        .i_Trap(c32.trap), .i_TrapVector(c32.tv[31:0]), .i_Mret(c32.mret), .i_Epc(c32.epc[31:0]),
        .o_PC(pc32), .o_PCLink(link32), .o_FetchValid(fv32), .o_Taken(taken32),
        .o_Misaligned(mis32), .o_BadAddr(bad32), .o_InstRet(ir32)
    );

    // Behavioural model: mode 0 = booting, 1 = running, 2 = faulted
    int          m_mode = 0;
    logic [63:0] m_pc   = '0;
    logic [63:0] m_ir   = '0;
    logic [63:0] m_bad  = '0;
    logic        m_mis  = 1'b0;

    function automatic bit cond_of(ctrl_t c);
        case (c.op)
            3'b000:  return c.eq;
            3'b001:  return !c.eq;
            3'b100:  return c.lt;
            3'b101:  return !c.lt;
            3'b110:  return c.ltu;
            3'b111:  return !c.ltu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_taken(ctrl_t c);
        bit jump;
        jump = c.jal || c.jalr || (c.br && cond_of(c));
        return (m_mode == 1) && c.rdy && !c.stall && jump;
    endfunction

    task automatic m_step(input ctrl_t c);
        bit          jump;
        logic [63:0] tgt;
        logic [63:0] sum;
        jump  = c.jal || c.jalr || (c.br && cond_of(c));
        m_mis = 1'b0;
        if (c.rst) begin
            m_mode = 0; m_pc = 64'h0; m_ir = 64'h0; m_bad = 64'h0;
        end else if (c.trap) begin
            m_pc = c.tv - (c.tv % 4); m_mode = 1;
        end else if (c.mret) begin
            m_pc = c.epc; m_mode = 1;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1 && c.rdy && !c.stall) begin
            sum = c.rs1 + c.imm;
            if (c.jalr)     tgt = sum - (sum % 2);
            else if (jump)  tgt = m_pc + c.imm;
            else            tgt = m_pc + 64'd4;
            if (jump && (tgt % 4) != 0) begin
                m_mode = 2; m_mis = 1'b1; m_bad = tgt;
            end else begin
                m_pc = tgt; m_ir = m_ir + 64'd1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ctrl_t c_idle();
        ctrl_t c;
        c = '0;
        c.rdy = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_br(logic [2:0] op, logic eq, logic lt, logic ltu, logic [63:0] imm);
        ctrl_t c;
        c = c_idle();
        c.br = 1'b1; c.op = op; c.eq = eq; c.lt = lt; c.ltu = ltu; c.imm = imm;
        return c;
    endfunction

    function automatic ctrl_t c_jal(logic [63:0] imm);
        ctrl_t c;
        c = c_idle(); c.jal = 1'b1; c.imm = imm;
        return c;
    endfunction

    function automatic ctrl_t c_jalr(logic [63:0] rs1, logic [63:0] imm);
        ctrl_t c;
        c = c_idle(); c.jalr = 1'b1; c.rs1 = rs1; c.imm = imm;
        return c;
    endfunction

    function automatic ctrl_t c_trap(logic [63:0] tv);
        ctrl_t c;
        c = c_idle(); c.trap = 1'b1; c.tv = tv;
        return c;
    endfunction

    function automatic ctrl_t c_mret(logic [63:0] epc);
        ctrl_t c;
        c = c_idle(); c.mret = 1'b1; c.epc = epc;
        return c;
    endfunction

    function automatic vec_t row(ctrl_t c, logic tk, logic [63:0] lk, logic [63:0] pc,
                                 logic [63:0] ir, logic fv, logic mis, logic [63:0] bad);
        vec_t v;
        v.c = c; v.taken = tk; v.link = lk; v.pc = pc; v.ir = ir; v.fv = fv; v.mis = mis; v.bad = bad;
        return v;
    endfunction

    // mode 0: drive only, 1: compare against table row, 2: compare against model
    task automatic cyc64(input ctrl_t c, input int mode, input vec_t v, input string tag);
        logic        e_tk;
        logic [63:0] e_lk;
        @(negedge clk);
        c64 = c;
        #1;
        if (mode == 1) begin
            e_tk = v.taken; e_lk = v.link;
        end else begin
            e_tk = m_taken(c); e_lk = m_pc + 64'd4;
        end
        if (mode != 0) begin
            chk({tag, " taken"}, 64'(taken64), 64'(e_tk));
            chk({tag, " link"}, link64, e_lk);
        end
        @(posedge clk);
        #1;
        m_step(c);
        if (mode == 1) begin
            chk({tag, " pc"}, pc64, v.pc);
            chk({tag, " instret"}, ir64, v.ir);
            chk({tag, " fetchvalid"}, 64'(fv64), 64'(v.fv));
            chk({tag, " misaligned"}, 64'(mis64), 64'(v.mis));
            chk({tag, " badaddr"}, bad64, v.bad);
        end else if (mode == 2) begin
            chk({tag, " pc"}, pc64, m_pc);
            chk({tag, " instret"}, ir64, m_ir);
            chk({tag, " fetchvalid"}, 64'(fv64), 64'(m_mode == 1));
            chk({tag, " misaligned"}, 64'(mis64), 64'(m_mis));
            chk({tag, " badaddr"}, bad64, m_bad);
        end
    endtask

    vec_t        tbl[24];
    vec_t        nov;
    ctrl_t       t;
    logic [31:0] r;
    logic [31:0] r2;

    initial begin
        c64 = c_idle(); c64.rst = 1'b1;
        c32 = c_idle(); c32.rst = 1'b1;
        nov = row('0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);

        tbl[0]  = row(c_idle() | ctrl_t'({1'b1, 206'b0}), 1'b0, 64'h4, 64'h0, 64'd0, 1'b0, 1'b0, 64'h0);
        tbl[1]  = row(c_idle(), 1'b0, 64'h4, 64'h0, 64'd0, 1'b1, 1'b0, 64'h0);
        tbl[2]  = row(c_idle(), 1'b0, 64'h4, 64'h4, 64'd1, 1'b1, 1'b0, 64'h0);
        tbl[3]  = row(c_idle(), 1'b0, 64'h8, 64'h8, 64'd2, 1'b1, 1'b0, 64'h0);
        tbl[4]  = row(c_trap(64'h100), 1'b0, 64'hC, 64'h100, 64'd2, 1'b1, 1'b0, 64'h0);
        tbl[5]  = row(c_br(3'b001, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8), 1'b1, 64'h104, 64'hF8, 64'd3, 1'b1, 1'b0, 64'h0);
        tbl[6]  = row(c_trap(64'h100), 1'b0, 64'hFC, 64'h100, 64'd3, 1'b1, 1'b0, 64'h0);
        tbl[7]  = row(c_br(3'b001, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8), 1'b0, 64'h104, 64'h104, 64'd4, 1'b1, 1'b0, 64'h0);
        tbl[8]  = row(c_jalr(64'h201, 64'h3), 1'b1, 64'h108, 64'h204, 64'd5, 1'b1, 1'b0, 64'h0);
        tbl[9]  = row(c_jal(64'h6), 1'b1, 64'h208, 64'h204, 64'd5, 1'b0, 1'b1, 64'h20A);
        tbl[10] = row(c_idle(), 1'b0, 64'h208, 64'h204, 64'd5, 1'b0, 1'b0, 64'h20A);
        tbl[11] = row(c_jal(64'h8), 1'b0, 64'h208, 64'h204, 64'd5, 1'b0, 1'b0, 64'h20A);
        tbl[12] = row(c_trap(64'h803), 1'b0, 64'h208, 64'h800, 64'd5, 1'b1, 1'b0, 64'h20A);
        t = c_jal(64'h40); t.stall = 1'b1;
        tbl[13] = row(t, 1'b0, 64'h804, 64'h800, 64'd5, 1'b1, 1'b0, 64'h20A);
        t = c_trap(64'h400); t.mret = 1'b1; t.epc = 64'h900; t.stall = 1'b1;
        tbl[14] = row(t, 1'b0, 64'h804, 64'h400, 64'd5, 1'b1, 1'b0, 64'h20A);
        tbl[15] = row(c_mret(64'h900), 1'b0, 64'h404, 64'h900, 64'd5, 1'b1, 1'b0, 64'h20A);
        t = c_idle(); t.rdy = 1'b0;
        tbl[16] = row(t, 1'b0, 64'h904, 64'h900, 64'd5, 1'b1, 1'b0, 64'h20A);
        tbl[17] = row(c_br(3'b110, 1'b0, 1'b0, 1'b1, 64'h10), 1'b1, 64'h904, 64'h910, 64'd6, 1'b1, 1'b0, 64'h20A);
        tbl[18] = row(c_br(3'b010, 1'b1, 1'b1, 1'b1, 64'h10), 1'b0, 64'h914, 64'h914, 64'd7, 1'b1, 1'b0, 64'h20A);
        tbl[19] = row(c_br(3'b101, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC), 1'b1, 64'h918, 64'h900, 64'd8, 1'b1, 1'b0, 64'h20A);
        tbl[20] = row(c_jal(64'h100), 1'b1, 64'h904, 64'hA00, 64'd9, 1'b1, 1'b0, 64'h20A);
        tbl[21] = row(c_jal(64'h2), 1'b1, 64'hA04, 64'hA00, 64'd9, 1'b0, 1'b1, 64'hA02);
        t = c_idle(); t.rst = 1'b1;
        tbl[22] = row(t, 1'b0, 64'hA04, 64'h0, 64'd0, 1'b0, 1'b0, 64'h0);
        tbl[23] = row(c_idle(), 1'b0, 64'h4, 64'h0, 64'd0, 1'b1, 1'b0, 64'h0);
        tbl[0].c.rst = 1'b1;

        t = c_idle(); t.rst = 1'b1;
        cyc64(t, 0, nov, "pre");
        cyc64(t, 0, nov, "pre");

        for (int i = 0; i < 24; i++) begin
            cyc64(tbl[i].c, 1, tbl[i], $sformatf("row%0d", i));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            t = '0;
            t.rdy   = ($urandom_range(3) != 0);
            t.stall = ($urandom_range(3) == 0);
            r  = $urandom;
            r2 = $urandom;
            t.imm = {{52{r[11]}}, r[11:2], (($urandom_range(7) == 0) ? r[1:0] : 2'b00)};
            t.rs1 = {32'h0, r2[31:2], (($urandom_range(3) == 0) ? r2[1:0] : 2'b00)};
            t.op  = 3'($urandom_range(7));
            t.eq  = 1'($urandom_range(1));
            t.lt  = 1'($urandom_range(1));
            t.ltu = 1'($urandom_range(1));
            case ($urandom_range(7))
                0, 1:    t.br   = 1'b1;
                2:       t.jal  = 1'b1;
                3:       t.jalr = 1'b1;
                default: t.br   = 1'b0;
            endcase
            t.trap = ($urandom_range(15) == 0);
            r = $urandom;
            t.tv   = {32'h0, r};
            t.mret = ($urandom_range(15) == 0);
            r = $urandom;
            t.epc  = {32'h0, r[31:2], 2'b00};
            t.rst  = ($urandom_range(49) == 0);
            cyc64(t, 2, nov, $sformatf("rnd%0d", i));
        end

        // 32-bit instance: reset vector, trap to top of space, sequential wrap
        @(negedge clk);
        c32 = c_idle(); c32.rst = 1'b1;
        @(posedge clk); #1;
        chk("w32 reset pc", 64'(pc32), 64'h1000);
        chk("w32 reset fetchvalid", 64'(fv32), 64'h0);
        chk("w32 reset instret", ir32, 64'h0);
        @(negedge clk);
        c32 = c_trap(64'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("w32 trap pc", 64'(pc32), 64'hFFFF_FFFC);
        chk("w32 trap fetchvalid", 64'(fv32), 64'h1);
        @(negedge clk);
        c32 = c_idle();
        #1;
        chk("w32 link wrap", 64'(link32), 64'h0);
        chk("w32 taken", 64'(taken32), 64'h0);
        @(posedge clk); #1;
        chk("w32 wrap pc", 64'(pc32), 64'h0);
        chk("w32 instret", ir32, 64'h1);
        chk("w32 misaligned", 64'(mis32), 64'h0);
        chk("w32 badaddr", 64'(bad32), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
